// File: rtl/shreg_univ.sv
// shreg_univ: universal shift register (hold/up/down/load) with saturating shift counter.
// Ports: clk (falling edge), r (async low reset), en, mode, du, dd, P -> Q, so_up, so_dn, cnt, done.
// Optional macro SHREG_ROTATE_EN adds input rot: rotate instead of serial input on shifts.
module shreg_univ #(
  parameter  int WIDTH = 4,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             r,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             du,
  input  logic             dd,
  input  logic [WIDTH-1:0] P,
`ifdef SHREG_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             so_up,
  output logic             so_dn,
  output logic [CW-1:0]    cnt,
  output logic             done
);

  localparam logic [1:0] M_HOLD = 2'b00;
  localparam logic [1:0] M_UP   = 2'b01;
  localparam logic [1:0] M_DN   = 2'b10;
  localparam logic [1:0] M_LOAD = 2'b11;

  localparam logic [CW-1:0] CMAX = CW'(WIDTH);

  logic [WIDTH-1:0] q_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic [CW-1:0]    cnt_inc;
  logic             in_up;
  logic             in_dn;

`ifdef SHREG_ROTATE_EN
  assign in_up = rot ? Q[WIDTH-1] : du;
  assign in_dn = rot ? Q[0] : dd;
`else
  assign in_up = du;
  assign in_dn = dd;
`endif

  // Counter saturates so done stays high through extra shifts.
  assign cnt_inc = (cnt == CMAX) ? cnt : cnt + 1'b1;

  always_comb begin
    q_nxt   = Q;
    cnt_nxt = cnt;
    if (en) begin
      unique case (mode)
        M_HOLD: begin
          q_nxt   = Q;
          cnt_nxt = cnt;
        end
        M_UP: begin
          q_nxt   = {Q[WIDTH-2:0], in_up};
          cnt_nxt = cnt_inc;
        end
        M_DN: begin
          q_nxt   = {in_dn, Q[WIDTH-1:1]};
          cnt_nxt = cnt_inc;
        end
        M_LOAD: begin
          q_nxt   = P;
          cnt_nxt = '0;
        end
        default: begin
          q_nxt   = Q;
          cnt_nxt = cnt;
        end
      endcase
    end
  end

  always_ff @(negedge clk or negedge r) begin
    if (!r) begin
      Q   <= '0;
      cnt <= '0;
    end else begin
      Q   <= q_nxt;
      cnt <= cnt_nxt;
    end
  end

  assign so_up = Q[WIDTH-1];
  assign so_dn = Q[0];
  assign done  = (cnt == CMAX);

endmodule

// File: tb/tb_shreg_univ.sv
// tb_shreg_univ: self-checking bench for shreg_univ (WIDTH=8).
// Directed scenarios plus randomized traffic against an arithmetic reference model.
module tb_shreg_univ;

  logic       clk;
  logic       r;
  logic       en;
  logic [1:0] mode;
  logic       du;
  logic       dd;
  logic [7:0] P;
  logic       rot;
  logic [7:0] Q;
  logic       so_up;
  logic       so_dn;
  logic [3:0] cnt;
  logic       done;

  int checks;
  int errors;

  int mq;
  int mcnt;

`ifdef SHREG_ROTATE_EN
  localparam bit ROT_ON = 1'b1;
`else
  localparam bit ROT_ON = 1'b0;
`endif

  shreg_univ #(.WIDTH(8)) dut (
    .clk   (clk),
    .r     (r),
    .en    (en),
    .mode  (mode),
    .du    (du),
    .dd    (dd),
    .P     (P),
`ifdef SHREG_ROTATE_EN
    .rot   (rot),
`endif
    .Q     (Q),
    .so_up (so_up),
    .so_dn (so_dn),
    .cnt   (cnt),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] exp_vec();
    logic [7:0] q8;
    q8 = 8'(mq);
    return {q8, 4'(mcnt), (mcnt == 8), q8[7], q8[0]};
  endfunction

  function automatic void model_step(
    input logic e, input logic [1:0] m, input logic u,
    input logic d, input logic [7:0] p, input logic rt);
    int bit_in;
    if (!r) begin
      mq = 0;
      mcnt = 0;
    end else if (e) begin
      if (m == 2'd1) begin
        bit_in = (ROT_ON && rt) ? (mq / 128) : int'(u);
        mq = ((mq * 2) % 256) + bit_in;
        mcnt = (mcnt < 8) ? mcnt + 1 : 8;
      end else if (m == 2'd2) begin
        bit_in = (ROT_ON && rt) ? (mq % 2) : int'(d);
        mq = (mq / 2) + bit_in * 128;
        mcnt = (mcnt < 8) ? mcnt + 1 : 8;
      end else if (m == 2'd3) begin
        mq = int'(p);
        mcnt = 0;
      end
    end
  endfunction

  // Drive inputs between edges, let one falling edge pass, return at
  // the following rising edge + 1 where outputs are sampled.
  task automatic tick(input logic e, input logic [1:0] m, input logic u,
                      input logic d, input logic [7:0] p, input logic rt);
    en = e; mode = m; du = u; dd = d; P = p; rot = rt;
    @(negedge clk);
    model_step(e, m, u, d, p, rt);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [14:0] act;
    r = 1'b0;
    en = 1'b0; mode = 2'd0; du = 1'b0; dd = 1'b0; P = 8'h00; rot = 1'b0;
    mq = 0; mcnt = 0;
    @(posedge clk); #1;
    r = 1'b1;
    tick(1'b1, 2'd3, 1'b0, 1'b0, 8'hA5, 1'b0);
    checks++;
    if (Q !== 8'hA5) begin
      errors++;
      $display("FAIL reset_preload Q=%h exp=%h", Q, 8'hA5);
    end
    #2;
    r = 1'b0;
    #1;
    mq = 0; mcnt = 0;
    checks++;
    if ({Q, cnt, done, so_up, so_dn} !== 15'd0) begin
      errors++;
      $display("FAIL reset_async Q=%h cnt=%0d done=%b exp 0", Q, cnt, done);
    end
    tick(1'b1, 2'd3, 1'b0, 1'b0, 8'hFF, 1'b0);
    tick(1'b1, 2'd3, 1'b0, 1'b0, 8'hFF, 1'b0);
    checks++;
    if ({Q, cnt, done} !== 13'd0) begin
      errors++;
      $display("FAIL reset_hold Q=%h cnt=%0d exp 0", Q, cnt);
    end
    r = 1'b1;
    tick(1'b1, 2'd3, 1'b0, 1'b0, 8'hFF, 1'b0);
    act = {Q, cnt, done, so_up, so_dn};
    checks++;
    if (act !== exp_vec() || Q !== 8'hFF) begin
      errors++;
      $display("FAIL reset_release got=%h exp=%h", act, exp_vec());
    end
  endtask

  task automatic test_load_hold();
    tick(1'b1, 2'd3, 1'b0, 1'b0, 8'h3C, 1'b0);
    checks++;
    if (Q !== 8'h3C || cnt !== 4'd0) begin
      errors++;
      $display("FAIL load Q=%h cnt=%0d exp 3c 0", Q, cnt);
    end
    for (int i = 0; i < 3; i++) tick(1'b1, 2'd0, 1'b1, 1'b1, 8'hFF, 1'b0);
    checks++;
    if (Q !== 8'h3C || cnt !== 4'd0) begin
      errors++;
      $display("FAIL hold Q=%h cnt=%0d exp 3c 0", Q, cnt);
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 2'd1, 1'b1, 1'b1, 8'hFF, 1'b0);
    checks++;
    if (Q !== 8'h3C || cnt !== 4'd0) begin
      errors++;
      $display("FAIL en_low Q=%h cnt=%0d exp 3c 0", Q, cnt);
    end
  endtask

  task automatic test_shift_up();
    logic [7:0] seq;
    seq = 8'b10110010;
    r = 1'b0;
    #1;
    mq = 0; mcnt = 0;
    @(posedge clk); #1;
    r = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      tick(1'b1, 2'd1, seq[i], 1'b0, 8'h00, 1'b0);
      checks++;
      if (done !== (i == 0)) begin
        errors++;
        $display("FAIL up_done step=%0d done=%b exp=%b", 7 - i, done, (i == 0));
      end
    end
    checks++;
    if (Q !== 8'b10110010 || cnt !== 4'd8 || done !== 1'b1) begin
      errors++;
      $display("FAIL deser Q=%b cnt=%0d done=%b exp 10110010 8 1", Q, cnt, done);
    end
    tick(1'b1, 2'd1, 1'b0, 1'b0, 8'h00, 1'b0);
    tick(1'b1, 2'd1, 1'b0, 1'b0, 8'h00, 1'b0);
    checks++;
    if (Q !== 8'b11001000 || cnt !== 4'd8 || done !== 1'b1) begin
      errors++;
      $display("FAIL up_sat Q=%b cnt=%0d exp 11001000 8", Q, cnt);
    end
  endtask

  task automatic test_shift_down();
    logic [7:0] exp_so;
    exp_so = 8'b10000001;
    tick(1'b1, 2'd3, 1'b0, 1'b0, 8'h81, 1'b0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (so_dn !== exp_so[7-i]) begin
        errors++;
        $display("FAIL ser_so_dn step=%0d got=%b exp=%b", i, so_dn, exp_so[7-i]);
      end
      tick(1'b1, 2'd2, 1'b0, 1'b0, 8'h00, 1'b0);
      checks++;
      if (done !== (i == 7)) begin
        errors++;
        $display("FAIL ser_done step=%0d got=%b exp=%b", i, done, (i == 7));
      end
    end
    checks++;
    if (Q !== 8'h00 || cnt !== 4'd8) begin
      errors++;
      $display("FAIL ser_final Q=%h cnt=%0d exp 00 8", Q, cnt);
    end
  endtask

  task automatic test_direction_mix();
    tick(1'b1, 2'd3, 1'b0, 1'b0, 8'h0F, 1'b0);
    tick(1'b1, 2'd1, 1'b1, 1'b0, 8'h00, 1'b0);
    checks++;
    if (Q !== 8'h1F || cnt !== 4'd1) begin
      errors++;
      $display("FAIL mix_up Q=%h cnt=%0d exp 1f 1", Q, cnt);
    end
    tick(1'b1, 2'd2, 1'b0, 1'b0, 8'h00, 1'b0);
    checks++;
    if (Q !== 8'h0F || cnt !== 4'd2 || done !== 1'b0) begin
      errors++;
      $display("FAIL mix_dn Q=%h cnt=%0d done=%b exp 0f 2 0", Q, cnt, done);
    end
  endtask

`ifdef SHREG_ROTATE_EN
  task automatic test_rotate();
    tick(1'b1, 2'd3, 1'b0, 1'b0, 8'h81, 1'b1);
    tick(1'b1, 2'd1, 1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if (Q !== 8'h03 || cnt !== 4'd1) begin
      errors++;
      $display("FAIL rot_up Q=%h cnt=%0d exp 03 1", Q, cnt);
    end
    tick(1'b1, 2'd3, 1'b0, 1'b0, 8'h81, 1'b1);
    for (int i = 0; i < 8; i++) tick(1'b1, 2'd2, 1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if (Q !== 8'h81 || done !== 1'b1) begin
      errors++;
      $display("FAIL rot_dn Q=%h done=%b exp 81 1", Q, done);
    end
  endtask
`endif

  task automatic test_random();
    logic [14:0] act;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        r = 1'b0;
        #1;
        mq = 0; mcnt = 0;
        checks++;
        if ({Q, cnt, done} !== 13'd0) begin
          errors++;
          $display("FAIL rand_rst it=%0d Q=%h cnt=%0d", i, Q, cnt);
        end
        @(posedge clk); #1;
        r = 1'b1;
      end
      tick(($urandom_range(0, 7) != 0), 2'($urandom), 1'($urandom),
           1'($urandom), 8'($urandom), 1'($urandom));
      act = {Q, cnt, done, so_up, so_dn};
      checks++;
      if (act !== exp_vec()) begin
        errors++;
        $display("FAIL rand it=%0d got=%h exp=%h", i, act, exp_vec());
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_load_hold();
    test_shift_up();
    test_shift_down();
    test_direction_mix();
`ifdef SHREG_ROTATE_EN
    test_rotate();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
